// File: rtl/sdram_responder.sv
// In-order SDRAM request responder: request FIFO, on-chip word storage, fixed-latency read pipe.
// Optional refresh engine compiled in when REFRESH_SDRAM_EN is defined.
module sdram_responder #(
  parameter int unsigned DEPTH_W        = 12,
  parameter int unsigned READ_LATENCY   = 3,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned REFRESH_PERIOD = 512,
  parameter int unsigned REFRESH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_read_en,
  input  logic        sdram_write_en,
  input  logic [25:0] address_sdram,
  input  logic [31:0] writeData_sdram,
  output logic [31:0] data_sdram,
  output logic        sdram_datareadvalid,
  output logic        sdram_waitrequest,
  output logic        refresh_active,
  output logic        overflow_err,
  output logic        range_err,
  output logic        protocol_err
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned Words = 1 << DEPTH_W;

  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (DEPTH_W < 1 || DEPTH_W > 25) begin : g_bad_depth
    $error("DEPTH_W must be in 1..25");
  end
  if (REFRESH_PERIOD < 2 || REFRESH_CYCLES < 1) begin : g_bad_refresh
    $error("REFRESH_PERIOD must be >= 2 and REFRESH_CYCLES >= 1");
  end

  logic               fifo_write_q [FIFO_DEPTH];
  logic [DEPTH_W-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [31:0]        fifo_data_q  [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [31:0]        mem_q [Words];

  logic               req, full, push, pop, stall, issue_read;
  logic               head_write;
  logic [DEPTH_W-1:0] head_addr;
  logic [31:0]        head_data;

  assign req        = sdram_read_en | sdram_write_en;
  assign full       = (count_q == CntW'(FIFO_DEPTH));
  assign push       = req & ~full;
  assign pop        = (count_q != '0) & ~stall;
  assign head_write = fifo_write_q[rd_ptr_q];
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign issue_read = pop & ~head_write;

  assign sdram_waitrequest = (count_q >= CntW'(FIFO_DEPTH - 1));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset; a read-and-write request queues as a write.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= sdram_write_en;
      fifo_addr_q[wr_ptr_q]  <= address_sdram[DEPTH_W-1:0];
      fifo_data_q[wr_ptr_q]  <= writeData_sdram;
    end
  end

  always_ff @(posedge clk) begin
    if (pop && head_write && !rst) mem_q[head_addr] <= head_data;
  end

  logic [31:0]             pipe_data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data_q[i] <= '0;
    end else begin
      pipe_valid_q[0] <= issue_read;
      pipe_data_q[0]  <= issue_read ? mem_q[head_addr] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  assign data_sdram          = pipe_data_q[READ_LATENCY-1];
  assign sdram_datareadvalid = pipe_valid_q[READ_LATENCY-1];

  logic overflow_q, range_q, protocol_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      range_q    <= 1'b0;
      protocol_q <= 1'b0;
    end else begin
      if (req && full)                                  overflow_q <= 1'b1;
      if (req && (address_sdram[25:DEPTH_W] != '0))     range_q    <= 1'b1;
      if (sdram_read_en && sdram_write_en)              protocol_q <= 1'b1;
    end
  end

  assign overflow_err = overflow_q;
  assign range_err    = range_q;
  assign protocol_err = protocol_q;

`ifdef REFRESH_SDRAM_EN
  typedef enum logic {StIdle, StRefresh} ref_state_e;

  ref_state_e  ref_state_q, ref_state_d;
  logic [31:0] ref_cnt_q, ref_cnt_d;

  // One counter serves both phases: idle period, then refresh length.
  always_comb begin
    ref_state_d = ref_state_q;
    ref_cnt_d   = ref_cnt_q + 32'd1;
    unique case (ref_state_q)
      StIdle: begin
        if (ref_cnt_q == REFRESH_PERIOD - 1) begin
          ref_state_d = StRefresh;
          ref_cnt_d   = '0;
        end
      end
      StRefresh: begin
        if (ref_cnt_q == REFRESH_CYCLES - 1) begin
          ref_state_d = StIdle;
          ref_cnt_d   = '0;
        end
      end
      default: ref_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_state_q <= StIdle;
      ref_cnt_q   <= '0;
    end else begin
      ref_state_q <= ref_state_d;
      ref_cnt_q   <= ref_cnt_d;
    end
  end

  assign stall = (ref_state_q == StRefresh);
`else
  assign stall = 1'b0;
`endif

  assign refresh_active = stall;

endmodule
